// File: rtl/byte_frame_fifo_pkg.sv
// Shared types for byte_frame_fifo: frame FSM states and the FIFO entry tag.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package byte_frame_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    // Frame-position flags stored beside each data byte. A full entry is
    // {eof, sof, data}; the data width is a module parameter, so the
    // entry struct itself is declared in byte_frame_fifo around this tag.
    typedef struct packed {
        logic eof;
        logic sof;
    } entry_tag_t;

    localparam int TAG_W = $bits(entry_tag_t);

    // Byte counter width; a 1-byte frame still needs a 1-bit counter.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/byte_frame_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH entries (power of two) of WIDTH bits.
// Latency: a write is visible on rd_vld/rd_dat the cycle after wr_vld.
// Backpressure: pops on rd_vld && rd_rdy; writes are dropped only when full with no pop.
module sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign rd_vld = (count_q != '0);
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && ((count_q != FULL_CNT) || do_rd);
    assign count  = count_q;
    // Zero the head while empty so the output never shows stale or unknown memory.
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/byte_frame_fifo.sv
// Frames a fixed-length byte stream into a FIFO, admitting a frame only if it fits whole.
// Latency: byte written on its input cycle, visible on m_valid one cycle later.
// Backpressure: m_valid/m_ready on output; input has none, so frames that do not fit are dropped.
// Optional stats outputs (frame_cnt, drop_cnt) are built when BYTE_FRAME_FIFO_STATS_EN is defined.
module byte_frame_fifo
    import byte_frame_fifo_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int COUNT = 33,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [BITS-1:0] b_in,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [BITS-1:0] m_data,
    output logic            m_sof,
    output logic            m_eof,
    output logic            overflow,
    output logic            proto_err
`ifdef BYTE_FRAME_FIFO_STATS_EN
    ,
    output logic [15:0]     frame_cnt,
    output logic [15:0]     drop_cnt
`endif
);

    typedef struct packed {
        entry_tag_t      tag;
        logic [BITS-1:0] data;
    } entry_t;

    localparam int CW = cnt_width(COUNT);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX  = CW'(COUNT - 1);
    // Admit when free space (DEPTH - occ) >= COUNT, i.e. occ <= DEPTH - COUNT.
    localparam logic [AW:0]   ADMIT_MAX = (AW+1)'(DEPTH - COUNT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          proto_err_q, proto_err_d;
    logic          wr_vld;
    entry_t        wr_entry;
    entry_t        rd_entry;
    logic [AW:0]   occ;
    logic          admit;

    // Occupancy before this cycle's pop, so a pop in the same cycle never over-admits.
    assign admit = (occ <= ADMIT_MAX);

    // Frame FSM: admission on frame start, then count the remaining bytes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        overflow_d    = overflow_q;
        proto_err_d   = proto_err_q;
        wr_vld        = 1'b0;
        wr_entry      = '0;
        wr_entry.data = b_in;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (admit) begin
                        wr_vld           = 1'b1;
                        wr_entry.tag.sof = 1'b1;
                        if (COUNT == 1) begin
                            wr_entry.tag.eof = 1'b1;
                        end else begin
                            state_d = RECV;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        overflow_d = 1'b1;
                        if (COUNT != 1) begin
                            state_d = DROP;
                            cnt_d   = CW'(1);
                        end
                    end
                end
            end
            RECV: begin
                wr_vld = 1'b1;
                if (start_in) proto_err_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    wr_entry.tag.eof = 1'b1;
                    state_d          = IDLE;
                    cnt_d            = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DROP: begin
                if (start_in) proto_err_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, byte counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BITS + TAG_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (wr_vld),
        .wr_dat (wr_entry),
        .rd_rdy (m_ready),
        .rd_vld (m_valid),
        .rd_dat (rd_entry),
        .count  (occ)
    );

    assign m_data    = rd_entry.data;
    assign m_sof     = rd_entry.tag.sof;
    assign m_eof     = rd_entry.tag.eof;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

`ifdef BYTE_FRAME_FIFO_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Accepted frames count on the eof write; drops count on entering a drop.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (wr_vld && wr_entry.tag.eof) frame_cnt_d = frame_cnt_q + 16'd1;
        if ((state_q == IDLE) && start_in && !admit) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Wrapping statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_byte_frame_fifo.sv
// Testbench for byte_frame_fifo: table vectors, directed corner sequences, random vs frame-level model.
// Latency: checks outputs each cycle at the falling edge.
// Backpressure: drives m_ready from tables, sequences and $urandom.
module tb_byte_frame_fifo;

    localparam int BITS  = 8;
    localparam int COUNT = 33;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_in;
    logic [BITS-1:0] b_in;
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;
    logic            m_sof;
    logic            m_eof;
    logic            overflow;
    logic            proto_err;
`ifdef BYTE_FRAME_FIFO_STATS_EN
    logic [15:0]     frame_cnt;
    logic [15:0]     drop_cnt;
`endif

    byte_frame_fifo #(.BITS(BITS), .COUNT(COUNT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .b_in      (b_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .overflow  (overflow),
        .proto_err (proto_err)
`ifdef BYTE_FRAME_FIFO_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Frame-level reference: a queue of {eof, sof, data} plus how many bytes of
    // the current frame are still to come and whether that frame was admitted.
    logic [BITS+1:0] mq [$];
    int              m_left;
    bit              m_keep;
    bit              m_ovf;
    bit              m_perr;
    logic [15:0]     m_frames;
    logic [15:0]     m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_left   = 0;
        m_keep   = 0;
        m_ovf    = 0;
        m_perr   = 0;
        m_frames = '0;
        m_drops  = '0;
    endtask

    task automatic model_step(input logic s, input logic [BITS-1:0] b, input logic r);
        int occ;
        occ = mq.size();
        if (occ != 0 && r) void'(mq.pop_front());
        if (m_left > 0) begin
            if (s) m_perr = 1;
            if (m_keep) begin
                mq.push_back({(m_left == 1), 1'b0, b});
                if (m_left == 1) m_frames++;
            end
            m_left--;
        end else if (s) begin
            if (DEPTH - occ >= COUNT) begin
                m_keep = 1;
                mq.push_back({(COUNT == 1), 1'b1, b});
                if (COUNT == 1) m_frames++;
            end else begin
                m_keep = 0;
                m_ovf  = 1;
                m_drops++;
            end
            m_left = COUNT - 1;
        end
    endtask

    task automatic check_outputs();
        chk("m_valid", m_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_data", m_data, mq[0][BITS-1:0]);
            chk("m_sof",  m_sof,  mq[0][BITS]);
            chk("m_eof",  m_eof,  mq[0][BITS+1]);
        end else begin
            chk("head_not_x", $isunknown({m_data, m_sof, m_eof}), 1'b0);
        end
        chk("overflow",  overflow,  m_ovf);
        chk("proto_err", proto_err, m_perr);
`ifdef BYTE_FRAME_FIFO_STATS_EN
        chk("frame_cnt", frame_cnt, m_frames);
        chk("drop_cnt",  drop_cnt,  m_drops);
`endif
    endtask

    // One clock cycle: drive inputs, check against the model, advance both.
    task automatic cycle(input logic s, input logic [BITS-1:0] b, input logic r);
        start_in = s;
        b_in     = b;
        m_ready  = r;
        #1;
        check_outputs();
        model_step(s, b, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        start_in = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_m_valid",   m_valid,   1'b0);
        chk("rst_overflow",  overflow,  1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Frame of bytes base..base+COUNT-1, with an optional stray start at byte stray_at.
    task automatic send_frame(input int base, input logic r, input int stray_at);
        for (int k = 0; k < COUNT; k++)
            cycle((k == 0) || (k == stray_at), BITS'(base + k), r);
    endtask

    task automatic drain(output int popped, output int frames, output int last_eof_dat);
        int guard;
        popped = 0;
        frames = 0;
        last_eof_dat = -1;
        guard = 0;
        while (mq.size() != 0 && guard < 200) begin
            if (m_valid === 1'b1) begin
                popped++;
                if (m_eof === 1'b1) begin
                    frames++;
                    last_eof_dat = int'(m_data);
                end
            end
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        chk("drain_timeout", (guard >= 200), 1'b0);
        cycle(1'b0, '0, 1'b1);
    endtask

    typedef struct {
        logic            start;
        logic [BITS-1:0] b;
        logic            rdy;
        logic            ev;
        logic [BITS-1:0] ed;
        logic            es;
        logic            ee;
    } vec_t;

    vec_t tbl [COUNT+2];

    initial begin
        int popped, frames, eof_dat, gen_left;

        // Single frame 0x00..0x20 streamed straight through with m_ready=1.
        for (int i = 0; i < COUNT + 2; i++) begin
            tbl[i].start = (i == 0);
            tbl[i].b     = (i < COUNT) ? BITS'(i) : '0;
            tbl[i].rdy   = 1'b1;
            tbl[i].ev    = (i >= 1) && (i <= COUNT);
            tbl[i].ed    = BITS'(i - 1);
            tbl[i].es    = (i == 1);
            tbl[i].ee    = (i == COUNT);
        end

        rst = 1'b1; start_in = 1'b0; b_in = '0; m_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("reset_m_valid",   m_valid,   1'b0);
        chk("reset_overflow",  overflow,  1'b0);
        chk("reset_proto_err", proto_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < COUNT + 2; i++) begin
            start_in = tbl[i].start; b_in = tbl[i].b; m_ready = tbl[i].rdy;
            #1;
            chk("tbl_valid", m_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_data", m_data, tbl[i].ed);
                chk("tbl_sof",  m_sof,  tbl[i].es);
                chk("tbl_eof",  m_eof,  tbl[i].ee);
            end
            cycle(tbl[i].start, tbl[i].b, tbl[i].rdy);
        end

        // Two back-to-back frames with the consumer stalled: second is dropped.
        do_reset();
        send_frame(8'h40, 1'b0, -1);
        send_frame(8'h80, 1'b0, -1);
        chk("b2b_overflow", overflow, 1'b1);
`ifdef BYTE_FRAME_FIFO_STATS_EN
        chk("b2b_drop_cnt", drop_cnt, 16'd1);
`endif
        drain(popped, frames, eof_dat);
        chk("b2b_popped", popped, COUNT);
        chk("b2b_frames", frames, 1);

        // Two pops free exactly COUNT slots: the next frame is admitted and fills the FIFO.
        do_reset();
        send_frame(8'h00, 1'b0, -1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        send_frame(8'h60, 1'b0, -1);
        chk("fit_overflow", overflow, 1'b0);
        drain(popped, frames, eof_dat);
        chk("fit_popped", popped, DEPTH);
        chk("fit_frames", frames, 2);

        // Stray start at byte 10 is data; frame still ends on its original byte 32.
        do_reset();
        send_frame(8'h00, 1'b0, 10);
        chk("stray_proto_err", proto_err, 1'b1);
        drain(popped, frames, eof_dat);
        chk("stray_popped",  popped,  COUNT);
        chk("stray_eof_dat", eof_dat, 32'h20);

        // Reset at byte 15: head empties at once, trailing bytes ignored, next frame intact.
        do_reset();
        for (int k = 0; k < 15; k++) cycle((k == 0), BITS'(k), 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", m_valid, 1'b0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 15; k < COUNT; k++) cycle(1'b0, BITS'(k), 1'b1);
        send_frame(8'hA0, 1'b0, -1);
        drain(popped, frames, eof_dat);
        chk("midrst_popped",  popped,  COUNT);
        chk("midrst_eof_dat", eof_dat, 32'hA0 + COUNT - 1);

        // Random traffic: random gaps, stalls and occasional stray starts.
        do_reset();
        gen_left = 0;
        for (int n = 0; n < 3000; n++) begin
            logic s;
            s = 1'b0;
            if (gen_left == 0) begin
                if ($urandom_range(3) == 0) begin
                    s = 1'b1;
                    gen_left = COUNT - 1;
                end
            end else begin
                s = ($urandom_range(63) == 0);
                gen_left--;
            end
            cycle(s, BITS'($urandom), ($urandom_range(2) != 0));
        end
        drain(popped, frames, eof_dat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
